// File: rtl/xor_parity_serializer_if.sv
// xor_parity_serializer_if: word handshake plus serial frame outputs of xor_parity_serializer
interface xor_parity_serializer_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic ser_out;
  logic ser_valid;
  logic ser_last;
  logic busy;
  logic word_parity;
  modport slave(input in_data, in_valid, output in_ready, ser_out, ser_valid, ser_last, busy, word_parity);
  modport master(output in_data, in_valid, input in_ready, ser_out, ser_valid, ser_last, busy, word_parity);
endinterface

// File: rtl/xor_parity_serializer.sv
// xor_parity_serializer: LSB-first word serializer with a trailing bit-serial parity bit
// Define ODD_PARITY_EN for odd parity; the default build emits even parity.
module xor_parity_serializer #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  xor_parity_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic acc, acc_n, accept, last_bit, ser_out_n;
  assign bus.in_ready = !rst && state != SHIFT;
  assign bus.busy = state != IDLE;
  assign accept = bus.in_valid && bus.in_ready;
  assign last_bit = cnt == CW'(WIDTH - 1);
  // Outputs are registered from the next-state values so the first data bit appears the cycle after accept
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    acc_n = acc;
    cnt_n = cnt;
    if (state == SHIFT) begin
      acc_n = acc ^ shreg[0];
      shreg_n = shreg >> 1;
      cnt_n = last_bit ? cnt : cnt + 1'b1;
      state_n = last_bit ? PARITY : SHIFT;
    end
    if (state == PARITY) state_n = IDLE;
    if (accept) begin
      shreg_n = bus.in_data;
      acc_n = 1'b0;
      cnt_n = '0;
      state_n = SHIFT;
    end
    ser_out_n = state_n == SHIFT ? shreg_n[0] : (state_n == PARITY && (acc_n ^ ODD));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      acc <= 1'b0;
      bus.ser_out <= 1'b0;
      bus.ser_valid <= 1'b0;
      bus.ser_last <= 1'b0;
      bus.word_parity <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt <= cnt_n;
      acc <= acc_n;
      bus.ser_out <= ser_out_n;
      bus.ser_valid <= state_n != IDLE;
      bus.ser_last <= state_n == PARITY;
      if (state == PARITY) bus.word_parity <= bus.ser_out;
    end
  end
endmodule

// File: tb/tb_xor_parity_serializer.sv
// tb_xor_parity_serializer: directed checks of framing, parity, back-to-back frames and mid-frame reset
module tb_xor_parity_serializer;
`ifdef ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  xor_parity_serializer_if #(.WIDTH(8)) bus();
  xor_parity_serializer #(.WIDTH(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Checks one full frame; at the first data bit switches the producer to (hold, nxt)
  task automatic run_frame(input logic [7:0] w, input logic even_par, input logic hold, input logic [7:0] nxt);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("data_bit", bus.ser_out, w[i]);
      chk("data_valid", bus.ser_valid, 1'b1);
      chk("data_last", bus.ser_last, 1'b0);
      chk("shift_ready", bus.in_ready, 1'b0);
      chk("shift_busy", bus.busy, 1'b1);
      if (i == 0) begin
        bus.in_valid = hold;
        bus.in_data = nxt;
      end
    end
    @(negedge clk);
    chk("parity_bit", bus.ser_out, even_par ^ ODD);
    chk("parity_valid", bus.ser_valid, 1'b1);
    chk("parity_last", bus.ser_last, 1'b1);
    chk("parity_ready", bus.in_ready, 1'b1);
  endtask
  task automatic after_frame(input logic even_par);
    @(negedge clk);
    chk("word_parity", bus.word_parity, even_par ^ ODD);
    chk("idle_valid", bus.ser_valid, 1'b0);
    chk("idle_last", bus.ser_last, 1'b0);
    chk("idle_out", bus.ser_out, 1'b0);
    chk("idle_busy", bus.busy, 1'b0);
  endtask
  initial begin
    bus.in_valid = 1'b1;
    bus.in_data = 8'h3C;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready", bus.in_ready, 1'b0);
      chk("rst_valid", bus.ser_valid, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_wp", bus.word_parity, 1'b0);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1 chk("ready_after_rst", bus.in_ready, 1'b1);
    @(negedge clk);
    chk("no_accept_valid", bus.ser_valid, 1'b0);
    chk("no_accept_busy", bus.busy, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    run_frame(8'hA5, 1'b0, 1'b0, 8'h5A);
    after_frame(1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h07;
    run_frame(8'h07, 1'b1, 1'b0, 8'hFF);
    after_frame(1'b1);
    bus.in_valid = 1'b1;
    bus.in_data = 8'h00;
    run_frame(8'h00, 1'b0, 1'b0, 8'h81);
    after_frame(1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hFF;
    run_frame(8'hFF, 1'b0, 1'b1, 8'h01);
    run_frame(8'h01, 1'b1, 1'b0, 8'h00);
    after_frame(1'b1);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("pre_rst_bit", bus.ser_out, 1'b0);
      chk("pre_rst_valid", bus.ser_valid, 1'b1);
      chk("pre_rst_wp", bus.word_parity, 1'b1 ^ ODD);
      bus.in_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", bus.ser_valid, 1'b0);
    chk("mid_rst_last", bus.ser_last, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_wp", bus.word_parity, 1'b0);
    #1 chk("mid_rst_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk("post_rst_idle", bus.ser_valid, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    run_frame(8'hA5, 1'b0, 1'b0, 8'h00);
    after_frame(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
